fetch_sequencer: RTL

Instruction-fetch controller that sequences the 16×8 program ROM. It owns the 4-bit program counter and drives the ROM address and read enable. It assembles one- and two-byte instructions (opcode plus optional imm8) and hands them to the decoder over a valid/ready handshake. It resolves `JMP` internally and parks on `HLT`.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_counter.sv | 36 +++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: opcode high nibbles, the fetch-state
// encoding and a helper that classifies an opcode by its byte count.
package cpu_pkg;

  localparam logic [3:0] OPC_LDI8_HI = 4'hB;
  localparam logic [3:0] OPC_JMP_HI  = 4'hC;
  localparam logic [3:0] OPC_HLT_HI  = 4'hF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    FETCH_IMM = 3'd2,
    ISSUE     = 3'd3,
    HALT      = 3'd4
  } fetch_state_e;

  // LDI8 and JMP carry an imm8 in the following ROM word.
  function automatic logic is_two_byte(input logic [3:0] opHi);
    return (opHi == OPC_LDI8_HI) || (opHi == OPC_JMP_HI);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: async reset to zero, wrapping increment, and a parallel
// load that takes priority over the increment.
module pc_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] loadValue_i,
  output logic [ADDR_W-1:0] count_o
);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks the program ROM, assembles one/two-byte
// instructions, issues them over valid/ready, resolves JMP and parks on HLT.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] imm_q, imm_d;

  logic              pcInc;
  logic              pcLoad;
  logic [ADDR_W-1:0] pcLoadValue;
  logic [ADDR_W-1:0] pcValue;

  logic [3:0] romHi;
  logic [3:0] irHi;

  assign romHi = rom_data[DATA_W-1 -: 4];
  assign irHi  = ir_q[DATA_W-1 -: 4];

  pc_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (pcInc),
    .load_i     (pcLoad),
    .loadValue_i(pcLoadValue),
    .count_o    (pcValue)
  );

  // JMP targets only use the low ADDR_W bits of the immediate.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    pcInc       = 1'b0;
    pcLoad      = 1'b0;
    pcLoadValue = imm_q[ADDR_W-1:0];
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        ir_d    = rom_data;
        pcInc   = 1'b1;
        state_d = is_two_byte(romHi) ? FETCH_IMM : ISSUE;
      end
      FETCH_IMM: begin
        imm_d   = rom_data;
        pcInc   = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (instr_ready) begin
          if (irHi == OPC_JMP_HI) begin
            pcLoad  = 1'b1;
            state_d = FETCH;
          end else if (irHi == OPC_HLT_HI) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  // Every handshake/ROM control output is a pure decode of the state register.
  assign rom_read_en = (state_q == FETCH) || (state_q == FETCH_IMM);
  assign instr_valid = (state_q == ISSUE);
  assign halted      = (state_q == HALT);
  assign rom_addr    = pcValue;
  assign pc          = pcValue;
  assign ir          = ir_q;
  assign imm         = imm_q;

endmodule
